round_timer: RTL

Countdown timer for a matching-game round. It counts whole seconds down from a programmable start value and freezes at zero. It supports start/restart, pause, and a time bonus that saturates. The 7-bit seconds value feeds the two-digit decimal display stage directly, so `val` must always stay in the range 0..99.

---
 rtl/round_timer.sv | 77 +++++++
 1 files changed

// File: rtl/round_timer.sv
// round_timer: whole-second round countdown with start/restart, pause and saturating bonus
//
// Parameters:
//   CLK_HZ    clock cycles per second (>= 2)
//   START_SEC seconds loaded on reset and on start (1..99)
//   BONUS_SEC seconds added per bonus pulse (0..99)
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    one-cycle pulse, starts or restarts the round (highest priority)
//   pause    level, holds the countdown while high
//   bonus    one-cycle pulse, adds BONUS_SEC (saturates at 99)
//   val      seconds remaining, 0..99, registered
//   running  high while in RUN
//   expired  high while in EXPIRED
//   time_up  one-cycle pulse on the edge val reaches 0
module round_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int START_SEC = 60,
  parameter int BONUS_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       bonus,
  output logic [6:0] val,
  output logic       running,
  output logic       expired,
  output logic       time_up
);
  localparam int PW = $clog2(CLK_HZ);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [6:0] val_nxt;
  logic [7:0] sum;
  logic active, tick, tu_nxt;
  // A PAUSED cycle with pause released already counts as a RUN cycle, so the
  // held prescaler advances on the same edge the state returns to RUN.
  always_comb begin
    active    = (state == RUN || state == PAUSED) && !pause;
    tick      = active && presc == PW'(CLK_HZ - 1);
    sum       = {1'b0, val} + (bonus ? 8'(BONUS_SEC) : 8'd0) - {7'd0, tick};
    state_nxt = state;
    presc_nxt = presc;
    val_nxt   = val;
    tu_nxt    = 1'b0;
    if (start) begin
      state_nxt = RUN;
      presc_nxt = '0;
      val_nxt   = 7'(START_SEC);
    end else if (state == RUN || state == PAUSED) begin
      val_nxt   = sum > 8'd99 ? 7'd99 : sum[6:0];
      presc_nxt = !active ? presc : tick ? '0 : presc + 1'b1;
      state_nxt = (tick && sum == 8'd0) ? EXPIRED : pause ? PAUSED : RUN;
      tu_nxt    = tick && sum == 8'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      val     <= 7'(START_SEC);
      running <= 1'b0;
      expired <= 1'b0;
      time_up <= 1'b0;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      val     <= val_nxt;
      running <= state_nxt == RUN;
      expired <= state_nxt == EXPIRED;
      time_up <= tu_nxt;
    end
  end
endmodule
